// File: rtl/core_sequencer.sv
// Stage sequencer for the multi-cycle RV32 core: cycles a slot counter through a
// configurable schedule and drives one active-low-enable hold per pipeline stage.
module core_sequencer #(
  parameter int unsigned                    PERIOD      = 8,
  parameter int unsigned                    CNT_W       = 3,
  parameter int unsigned                    NUM_STAGES  = 3,
  parameter logic [NUM_STAGES*CNT_W-1:0]    STAGE_SLOTS = {3'd5, 3'd4, 3'd0},
  parameter int unsigned                    RET_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  stall_req,
  input  logic                  retire_early,
  output logic [NUM_STAGES-1:0] hold,
  output logic [CNT_W-1:0]      slot,
  output logic                  running,
  output logic                  retire,
  output logic [RET_W-1:0]      instret
);

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   slot_q, slot_d;
  logic [RET_W-1:0]   instret_q, instret_d;
  logic               advance;
  logic               wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      instret_q <= instret_d;
    end
  end

  // Reset overrides everything, so an abandoned instruction never retires or enables a stage.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    instret_d = instret_q;
    hold      = '1;

    advance = (state_q != IDLE) && !stall_req && !rst;
    wrap    = advance && ((slot_q == LAST_SLOT) || retire_early);

    if (wrap) begin
      slot_d    = '0;
      instret_d = instret_q + RET_W'(1);
    end else if (advance) begin
      slot_d = slot_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = DRAIN;
      DRAIN: begin
        if (en)        state_d = RUN;
        else if (wrap) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      hold[i] = !(advance && (slot_q == STAGE_SLOTS[i*int'(CNT_W) +: CNT_W]));
    end

    retire  = wrap;
    running = (state_q != IDLE);
    slot    = slot_q;
    instret = instret_q;
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: default schedule plus a 5-slot, 4-stage variant.
module tb_core_sequencer;

  localparam logic [4:0] FULL   = 5'h1f;
  localparam logic [4:0] NOHOLD = 5'h1e;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_a = 1'b0, en_b = 1'b0, stall = 1'b0, re = 1'b0;

  logic [2:0]  hold_a;
  logic [2:0]  slot_a;
  logic        running_a, retire_a;
  logic [31:0] instret_a;
  logic [3:0]  hold_b;
  logic [2:0]  slot_b;
  logic        running_b, retire_b;
  logic [3:0]  instret_b;

  core_sequencer dut_a (
    .clk(clk), .rst(rst), .en(en_a), .stall_req(stall), .retire_early(re),
    .hold(hold_a), .slot(slot_a), .running(running_a), .retire(retire_a), .instret(instret_a)
  );

  core_sequencer #(
    .PERIOD(5), .CNT_W(3), .NUM_STAGES(4),
    .STAGE_SLOTS({3'd2, 3'd2, 3'd1, 3'd0}), .RET_W(4)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .stall_req(stall), .retire_early(re),
    .hold(hold_b), .slot(slot_b), .running(running_b), .retire(retire_b), .instret(instret_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sel;
    logic [4:0] m;
    logic [3:0] h;
    int         s;
    logic       run;
    logic       ret;
    int         inst;
  } exp_t;

  exp_t exp_q[$];
  int   ret_qa[$];
  int   ret_qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Hand-derived hold decode tables for the two schedules.
  function automatic logic [3:0] dec_a(input int s);
    case (s)
      0:       return 4'b0110;
      4:       return 4'b0101;
      5:       return 4'b0011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic logic [3:0] dec_b(input int s);
    case (s)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  task automatic step(input logic sel, input logic r, input logic e, input logic st,
                      input logic rq, input logic [4:0] m, input logic [3:0] h, input int s,
                      input logic run, input logic ret, input int inst);
    exp_t x;
    @(posedge clk);
    #1;
    rst   = r;
    en_a  = sel ? 1'b0 : e;
    en_b  = sel ? e : 1'b0;
    stall = st;
    re    = rq;
    x = '{sel: sel, m: m, h: h, s: s, run: run, ret: ret, inst: inst};
    exp_q.push_back(x);
    if (ret) begin
      if (sel) ret_qb.push_back(inst);
      else     ret_qa.push_back(inst);
    end
  endtask

  task automatic a(input logic e, input logic st, input logic rq, input logic [3:0] h,
                   input int s, input logic run, input logic ret, input int inst);
    step(1'b0, 1'b0, e, st, rq, FULL, h, s, run, ret, inst);
  endtask

  // Per-cycle monitor: compares the selected DUT against the expectation issued for this cycle.
  exp_t        mx;
  logic [31:0] m_h, m_s, m_i;
  logic        m_r, m_t;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mx = exp_q.pop_front();
      if (mx.sel) begin
        m_h = 32'(hold_b); m_s = 32'(slot_b); m_r = running_b; m_t = retire_b; m_i = 32'(instret_b);
      end else begin
        m_h = 32'(hold_a); m_s = 32'(slot_a); m_r = running_a; m_t = retire_a; m_i = instret_a;
      end
      if (mx.m[0]) chk("hold", m_h, 32'(mx.h));
      if (mx.m[1]) chk("slot", m_s, 32'(mx.s));
      if (mx.m[2]) chk("running", 32'(m_r), 32'(mx.run));
      if (mx.m[3]) chk("retire", 32'(m_t), 32'(mx.ret));
      if (mx.m[4]) chk("instret", m_i, 32'(mx.inst));
    end
  end

  // Retire monitor: every retire pulse must match a queued expectation of the pre-increment count.
  int rv;
  always @(negedge clk) begin
    if (retire_a === 1'b1) begin
      if (ret_qa.size() == 0) chk("unexpected_retire_a", 32'(instret_a), 32'hdead);
      else begin rv = ret_qa.pop_front(); chk("retire_count_a", instret_a, 32'(rv)); end
    end
    if (retire_b === 1'b1) begin
      if (ret_qb.size() == 0) chk("unexpected_retire_b", 32'(instret_b), 32'hdead);
      else begin rv = ret_qb.pop_front(); chk("retire_count_b", 32'(instret_b), 32'(rv % 16)); end
    end
  end

  initial begin
    int ic;
    // Reset, then check the idle state and the non-advancing IDLE->RUN cycle.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 4'h7, 0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, FULL, 4'h7, 0, 1'b0, 1'b0, 0);
    a(1'b1, 1'b0, 1'b0, 4'h7, 0, 1'b0, 1'b0, 0);
    ic = 0;
    for (int i = 0; i < 24; i++) begin
      a(1'b1, 1'b0, 1'b0, dec_a(i % 8), i % 8, 1'b1, (i % 8) == 7, ic);
      if ((i % 8) == 7) ic++;
    end
    // Three-cycle stall at slot 4.
    for (int s = 0; s < 4; s++) a(1'b1, 1'b0, 1'b0, dec_a(s), s, 1'b1, 1'b0, ic);
    for (int k = 0; k < 3; k++) a(1'b1, 1'b1, 1'b0, 4'h7, 4, 1'b1, 1'b0, ic);
    for (int s = 4; s < 8; s++) a(1'b1, 1'b0, 1'b0, dec_a(s), s, 1'b1, s == 7, ic);
    ic++;
    // Early retire at slot 5.
    for (int s = 0; s < 5; s++) a(1'b1, 1'b0, 1'b0, dec_a(s), s, 1'b1, 1'b0, ic);
    a(1'b1, 1'b0, 1'b1, 4'b0011, 5, 1'b1, 1'b1, ic);
    ic++;
    // Early retire under stall is ignored.
    for (int s = 0; s < 2; s++) a(1'b1, 1'b0, 1'b0, dec_a(s), s, 1'b1, 1'b0, ic);
    a(1'b1, 1'b1, 1'b1, 4'h7, 2, 1'b1, 1'b0, ic);
    for (int s = 2; s < 8; s++) a(1'b1, 1'b0, 1'b0, dec_a(s), s, 1'b1, s == 7, ic);
    ic++;
    // en dropped at slot 2: drain to IDLE.
    for (int s = 0; s < 2; s++) a(1'b1, 1'b0, 1'b0, dec_a(s), s, 1'b1, 1'b0, ic);
    for (int s = 2; s < 8; s++) a(1'b0, 1'b0, 1'b0, dec_a(s), s, 1'b1, s == 7, ic);
    ic++;
    a(1'b0, 1'b0, 1'b0, 4'h7, 0, 1'b0, 1'b0, ic);
    a(1'b0, 1'b0, 1'b0, 4'h7, 0, 1'b0, 1'b0, ic);
    // Restart, drop en at slot 1, re-assert at slot 6 of DRAIN.
    a(1'b1, 1'b0, 1'b0, 4'h7, 0, 1'b0, 1'b0, ic);
    a(1'b1, 1'b0, 1'b0, dec_a(0), 0, 1'b1, 1'b0, ic);
    for (int s = 1; s < 6; s++) a(1'b0, 1'b0, 1'b0, dec_a(s), s, 1'b1, 1'b0, ic);
    for (int s = 6; s < 8; s++) a(1'b1, 1'b0, 1'b0, dec_a(s), s, 1'b1, s == 7, ic);
    ic++;
    // Two full instructions, then reset at slot 5 of the third.
    for (int i = 0; i < 16; i++) begin
      a(1'b1, 1'b0, 1'b0, dec_a(i % 8), i % 8, 1'b1, (i % 8) == 7, ic);
      if ((i % 8) == 7) ic++;
    end
    for (int s = 0; s < 5; s++) a(1'b1, 1'b0, 1'b0, dec_a(s), s, 1'b1, 1'b0, ic);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, NOHOLD, 4'h7, 5, 1'b1, 1'b0, ic);
    a(1'b0, 1'b0, 1'b0, 4'h7, 0, 1'b0, 1'b0, 0);
    // Alternate schedule: 17 instructions of 5 slots, 4-bit instret wraps to 1.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, FULL, 4'hf, 0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 85; i++)
      step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, FULL, dec_b(i % 5), i % 5, 1'b1, (i % 5) == 4, (i / 5) % 16);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, FULL, 4'b1110, 0, 1'b1, 1'b0, 1);
    @(negedge clk);
    #1;
    chk("leftover_retires_a", 32'(ret_qa.size()), 32'd0);
    chk("leftover_retires_b", 32'(ret_qb.size()), 32'd0);
    chk("leftover_expect", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
